// File: rtl/coder_n_pipe.sv
// coder_n_pipe: registered index decoder with one-hot, thermometer and walk modes.
// Walk mode emits one-hot beats from the requested index up to the top bit,
// one beat per output transfer, under valid/ready flow control on both sides.
module coder_n_pipe #(
    parameter int unsigned IDX_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [IDX_W-1:0]   index,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2**IDX_W-1:0] result,
    output logic               last,
    output logic               busy
);
    localparam int unsigned OUT_W = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] MaxIdx = IDX_W'(OUT_W - 1);

    typedef enum logic {StIdle, StWalk} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [OUT_W-1:0]   result_q, result_d;
    logic               last_q, last_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic               xfer;
    logic [IDX_W-1:0]   cnt_inc;
    logic [OUT_W-1:0]   onehot_in;
    logic [OUT_W-1:0]   therm_in;

    // Handshake qualifiers; in_ready is forced low while reset is asserted.
    assign in_ready = rst_n && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign xfer     = out_valid_q && out_ready;
    assign cnt_inc  = cnt_q + IDX_W'(1);

    // Decode the incoming index into one-hot and thermometer words.
    always_comb begin
        onehot_in = OUT_W'(1) << index;
        therm_in  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            therm_in[i] = (i <= int'(index));
        end
    end

    // Next-state: new request, walk advance, or drain after final transfer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        last_d      = last_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            last_d      = 1'b1;
            unique case (mode)
                2'b00: result_d = onehot_in;
                2'b01: result_d = therm_in;
                2'b10: begin
                    result_d = onehot_in;
                    cnt_d    = index;
                    // Starting at the top bit is already the final beat.
                    if (index != MaxIdx) begin
                        last_d  = 1'b0;
                        state_d = StWalk;
                    end
                end
                default: result_d = '0;
            endcase
        end else if (state_q == StWalk && xfer) begin
            // In StWalk cnt_q < MaxIdx, so the increment never wraps.
            cnt_d    = cnt_inc;
            result_d = OUT_W'(1) << cnt_inc;
            if (cnt_inc == MaxIdx) begin
                last_d  = 1'b1;
                state_d = StIdle;
            end
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            result_q    <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign last      = last_q;
    assign busy      = (state_q == StWalk);

endmodule

// File: tb/tb_coder_n_pipe.sv
// Directed bench for coder_n_pipe: IDX_W=2 and IDX_W=3 instances on one clock.
module tb_coder_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_last, a_busy;
    logic [1:0] a_index, a_mode;
    logic [3:0] a_result;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_last, b_busy;
    logic [2:0] b_index;
    logic [1:0] b_mode;
    logic [7:0] b_result;

    coder_n_pipe #(.IDX_W(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .index     (a_index),
        .mode      (a_mode),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .result    (a_result),
        .last      (a_last),
        .busy      (a_busy)
    );

    coder_n_pipe #(.IDX_W(3)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .index     (b_index),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .result    (b_result),
        .last      (b_last),
        .busy      (b_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [1:0] index;
        logic [3:0] exp_result;
        logic       exp_last;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{2'b00, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[1] = '{2'b00, 2'd1, 4'b0010, 1'b1, 1'b0};
        vecs[2] = '{2'b00, 2'd2, 4'b0100, 1'b1, 1'b0};
        vecs[3] = '{2'b00, 2'd3, 4'b1000, 1'b1, 1'b0};
        vecs[4] = '{2'b01, 2'd3, 4'b1111, 1'b1, 1'b0};
        vecs[5] = '{2'b01, 2'd0, 4'b0001, 1'b1, 1'b0};
        vecs[6] = '{2'b01, 2'd2, 4'b0111, 1'b1, 1'b0};
        vecs[7] = '{2'b11, 2'd2, 4'b0000, 1'b1, 1'b0};
        vecs[8] = '{2'b11, 2'd0, 4'b0000, 1'b1, 1'b0};
        vecs[9] = '{2'b10, 2'd3, 4'b1000, 1'b1, 1'b0};

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_index = '0; a_mode = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_index = '0; b_mode = '0; b_out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_result",    32'(a_result),    32'd0);
        chk("rst_last",      32'(a_last),      32'd0);
        chk("rst_busy",      32'(a_busy),      32'd0);
        chk("rst_in_ready",  32'(a_in_ready),  32'd0);
        chk("rst_b_valid",   32'(b_out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

        // Back-to-back single-beat table, out_ready held high.
        a_out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a_in_valid = 1'b1;
            a_mode     = vecs[i].mode;
            a_index    = vecs[i].index;
            tick();
            chk($sformatf("vec%0d_valid", i),  32'(a_out_valid), 32'd1);
            chk($sformatf("vec%0d_result", i), 32'(a_result),    32'(vecs[i].exp_result));
            chk($sformatf("vec%0d_last", i),   32'(a_last),      32'(vecs[i].exp_last));
            chk($sformatf("vec%0d_busy", i),   32'(a_busy),      32'(vecs[i].exp_busy));
        end
        a_in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(a_out_valid), 32'd0);

        // Walk from index 1 with a one-cycle stall on the first beat.
        a_in_valid = 1'b1; a_mode = 2'b10; a_index = 2'd1;
        tick();
        a_in_valid = 1'b0;
        chk("walk1_b0_result", 32'(a_result), 32'b0010);
        chk("walk1_b0_last",   32'(a_last),   32'd0);
        chk("walk1_b0_busy",   32'(a_busy),   32'd1);
        a_out_ready = 1'b0;
        tick();
        chk("walk1_stall_result", 32'(a_result),    32'b0010);
        chk("walk1_stall_valid",  32'(a_out_valid), 32'd1);
        a_out_ready = 1'b1;
        tick();
        chk("walk1_b1_result", 32'(a_result),   32'b0100);
        chk("walk1_b1_last",   32'(a_last),     32'd0);
        chk("walk1_b1_ready",  32'(a_in_ready), 32'd0);
        tick();
        chk("walk1_b2_result", 32'(a_result),   32'b1000);
        chk("walk1_b2_last",   32'(a_last),     32'd1);
        chk("walk1_b2_busy",   32'(a_busy),     32'd0);
        chk("walk1_b2_ready",  32'(a_in_ready), 32'd1);
        tick();
        chk("walk1_nowrap_valid", 32'(a_out_valid), 32'd0);

        // Backpressure: result held, second request blocked until out_ready.
        a_in_valid = 1'b1; a_mode = 2'b00; a_index = 2'd1; a_out_ready = 1'b0;
        tick();
        a_index = 2'd3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("bp%0d_result", i), 32'(a_result),    32'b0010);
            chk($sformatf("bp%0d_valid", i),  32'(a_out_valid), 32'd1);
            chk($sformatf("bp%0d_ready", i),  32'(a_in_ready),  32'd0);
            tick();
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a_in_ready), 32'd1);
        tick();
        a_in_valid = 1'b0;
        chk("bp_second_result", 32'(a_result), 32'b1000);
        chk("bp_second_last",   32'(a_last),   32'd1);
        tick();
        chk("bp_drain_valid", 32'(a_out_valid), 32'd0);

        // Reset asserted mid-walk aborts the sequence.
        a_in_valid = 1'b1; a_mode = 2'b10; a_index = 2'd0;
        tick();
        a_in_valid = 1'b0;
        chk("rw_b0_result", 32'(a_result), 32'b0001);
        chk("rw_b0_busy",   32'(a_busy),   32'd1);
        tick();
        chk("rw_b1_result", 32'(a_result), 32'b0010);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rw_rst_valid",  32'(a_out_valid), 32'd0);
        chk("rw_rst_busy",   32'(a_busy),      32'd0);
        chk("rw_rst_result", 32'(a_result),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rw_after_valid0", 32'(a_out_valid), 32'd0);
        tick();
        chk("rw_after_valid1", 32'(a_out_valid), 32'd0);
        chk("rw_after_busy",   32'(a_busy),      32'd0);
        a_in_valid = 1'b1; a_mode = 2'b00; a_index = 2'd2;
        tick();
        a_in_valid = 1'b0;
        chk("rw_next_result", 32'(a_result), 32'b0100);
        chk("rw_next_last",   32'(a_last),   32'd1);

        // IDX_W=3 walk from index 5.
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_mode = 2'b10; b_index = 3'd5;
        tick();
        b_in_valid = 1'b0;
        chk("w3_b0_result", 32'(b_result),   32'h20);
        chk("w3_b0_last",   32'(b_last),     32'd0);
        chk("w3_b0_busy",   32'(b_busy),     32'd1);
        chk("w3_b0_ready",  32'(b_in_ready), 32'd0);
        tick();
        chk("w3_b1_result", 32'(b_result),   32'h40);
        chk("w3_b1_last",   32'(b_last),     32'd0);
        chk("w3_b1_busy",   32'(b_busy),     32'd1);
        chk("w3_b1_ready",  32'(b_in_ready), 32'd0);
        tick();
        chk("w3_b2_result", 32'(b_result),   32'h80);
        chk("w3_b2_last",   32'(b_last),     32'd1);
        chk("w3_b2_busy",   32'(b_busy),     32'd0);
        chk("w3_b2_ready",  32'(b_in_ready), 32'd1);
        tick();
        chk("w3_end_valid", 32'(b_out_valid), 32'd0);

        // IDX_W=3 top-index thermometer and one-hot.
        b_in_valid = 1'b1; b_mode = 2'b01; b_index = 3'd7;
        tick();
        chk("w3_therm7", 32'(b_result), 32'hFF);
        b_mode = 2'b00; b_index = 3'd7;
        tick();
        b_in_valid = 1'b0;
        chk("w3_onehot7", 32'(b_result), 32'h80);
        chk("w3_onehot7_valid", 32'(b_out_valid), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
